// File: rtl/if_fetch.sv
// Instruction-fetch controller: one outstanding imem read per PC, holds the word for decode,
// and pulses pc_reg's load enable on accepted fetches and redirects.
module if_fetch #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pc,
  input  logic             redirect,
  output logic             pc_en,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             instr_valid,
  output logic [XLEN-1:0]  instr,
  output logic [XLEN-1:0]  instr_pc,
  input  logic             instr_ready,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pend_pc_q, instr_q, instr_pc_q;
  logic             drop_q;
  logic [CNT_W-1:0] cnt_q;

  logic handshake;
  logic capture_pc;
  logic load_instr;
  logic set_drop;
  logic clr_drop;
  logic deliver;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (handshake) state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid) state_d = (drop_q || redirect) ? StReq : StHold;
      end
      StHold: begin
        if (redirect || instr_ready) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath-control logic
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    capture_pc  = 1'b0;
    load_instr  = 1'b0;
    set_drop    = 1'b0;
    clr_drop    = 1'b0;
    deliver     = 1'b0;
    unique case (state_q)
      StReq: begin
        // Masking the request keeps a redirect and a handshake from ever coinciding.
        imem_req  = !redirect;
        imem_addr = pc;
      end
      StWait: begin
        if (imem_rvalid) begin
          if (drop_q || redirect) clr_drop = 1'b1;
          else                    load_instr = 1'b1;
        end else if (redirect) begin
          set_drop = 1'b1;
        end
      end
      StHold: begin
        instr_valid = 1'b1;
        deliver     = instr_ready && !redirect;
      end
      default: ;
    endcase
    handshake = imem_req && imem_ready;
    if (handshake) capture_pc = 1'b1;
  end

  // Gated by rst_n so a redirect seen during reset never loads pc_reg.
  assign pc_en = rst_n && (handshake || redirect);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_pc_q  <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (capture_pc) pend_pc_q <= pc;
      if (load_instr) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pend_pc_q;
      end
      if (set_drop)      drop_q <= 1'b1;
      else if (clr_drop) drop_q <= 1'b0;
      if (deliver) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign instr     = instr_q;
  assign instr_pc  = instr_pc_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, reset corner sequence, then randomized traffic
// against a flag-based behavioural model with a pc_reg and latency-randomized memory.
module tb_if_fetch;

  logic        clk, rst_n, redirect, imem_ready, imem_rvalid, instr_ready;
  logic [31:0] pc, imem_rdata;
  logic        pc_en, imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc, fetch_cnt;

  int checks   = 0;
  int failures = 0;

  if_fetch #(.XLEN(32), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .redirect   (redirect),
    .pc_en      (pc_en),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .fetch_cnt  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, rdy, rv, ir;
    logic [31:0] pc, rdata;
    logic        e_pe, e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_instr, e_ipc, e_cnt;
  } vec_t;

  function automatic vec_t v(input logic rd, rdy, rv, ir, input logic [31:0] p, rdata,
                             input logic epe, ereq, input logic [31:0] eaddr,
                             input logic evl, input logic [31:0] ei, eipc, ecnt);
    vec_t r;
    r.rd = rd; r.rdy = rdy; r.rv = rv; r.ir = ir; r.pc = p; r.rdata = rdata;
    r.e_pe = epe; r.e_req = ereq; r.e_addr = eaddr; r.e_val = evl;
    r.e_instr = ei; r.e_ipc = eipc; r.e_cnt = ecnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic epe, ereq, input logic [31:0] eaddr,
                         input logic evl, input logic [31:0] ei, eipc, ecnt);
    chk({tag, " pc_en"}, {31'd0, pc_en}, {31'd0, epe});
    chk({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, ereq});
    chk({tag, " imem_addr"}, imem_addr, eaddr);
    chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, evl});
    chk({tag, " instr"}, instr, ei);
    chk({tag, " instr_pc"}, instr_pc, eipc);
    chk({tag, " fetch_cnt"}, fetch_cnt, ecnt);
  endtask

  vec_t tbl[30];

  // Behavioural model state
  bit          m_started, m_busy, m_hold, m_drop, mem_pend;
  int          mem_lat;
  logic [31:0] m_instr, m_ipc, m_pend, m_cnt, tpc, tgt;
  logic        e_fetch, e_req, e_pe;

  initial begin
    tbl[0]  = v(0,1,0,1, 32'h0,   32'h0,        0,0,32'h0,   0,32'h0,        32'h0,  0);
    tbl[1]  = v(0,1,0,1, 32'h0,   32'h0,        1,1,32'h0,   0,32'h0,        32'h0,  0);
    tbl[2]  = v(0,1,1,1, 32'h4,   32'h00500093, 0,0,32'h0,   0,32'h0,        32'h0,  0);
    tbl[3]  = v(0,1,0,1, 32'h4,   32'h0,        0,0,32'h0,   1,32'h00500093, 32'h0,  0);
    tbl[4]  = v(0,1,0,1, 32'h4,   32'h0,        1,1,32'h4,   0,32'h00500093, 32'h0,  1);
    tbl[5]  = v(0,1,1,0, 32'h8,   32'h00100113, 0,0,32'h0,   0,32'h00500093, 32'h0,  1);
    for (int i = 6; i <= 10; i++)
      tbl[i] = v(0,1,0,0, 32'h8,  32'h0,        0,0,32'h0,   1,32'h00100113, 32'h4,  1);
    tbl[11] = v(0,1,0,1, 32'h8,   32'h0,        0,0,32'h0,   1,32'h00100113, 32'h4,  1);
    for (int i = 12; i <= 15; i++)
      tbl[i] = v(0,0,0,1, 32'h8,  32'h0,        0,1,32'h8,   0,32'h00100113, 32'h4,  2);
    tbl[16] = v(0,1,0,1, 32'h8,   32'h0,        1,1,32'h8,   0,32'h00100113, 32'h4,  2);
    tbl[17] = v(0,1,0,1, 32'hc,   32'h0,        0,0,32'h0,   0,32'h00100113, 32'h4,  2);
    tbl[18] = v(0,1,0,1, 32'hc,   32'h0,        0,0,32'h0,   0,32'h00100113, 32'h4,  2);
    tbl[19] = v(0,1,1,1, 32'hc,   32'h00208193, 0,0,32'h0,   0,32'h00100113, 32'h4,  2);
    tbl[20] = v(0,1,0,1, 32'hc,   32'h0,        0,0,32'h0,   1,32'h00208193, 32'h8,  2);
    tbl[21] = v(0,1,0,1, 32'hc,   32'h0,        1,1,32'hc,   0,32'h00208193, 32'h8,  3);
    tbl[22] = v(1,1,0,1, 32'h10,  32'h0,        1,0,32'h0,   0,32'h00208193, 32'h8,  3);
    tbl[23] = v(0,1,1,1, 32'h100, 32'h11111111, 0,0,32'h0,   0,32'h00208193, 32'h8,  3);
    tbl[24] = v(0,1,0,1, 32'h100, 32'h0,        1,1,32'h100, 0,32'h00208193, 32'h8,  3);
    tbl[25] = v(1,1,1,1, 32'h104, 32'h22222222, 1,0,32'h0,   0,32'h00208193, 32'h8,  3);
    tbl[26] = v(0,1,0,1, 32'h100, 32'h0,        1,1,32'h100, 0,32'h00208193, 32'h8,  3);
    tbl[27] = v(0,1,1,1, 32'h104, 32'hdeadbeef, 0,0,32'h0,   0,32'h00208193, 32'h8,  3);
    tbl[28] = v(1,1,0,1, 32'h104, 32'h0,        1,0,32'h0,   1,32'hdeadbeef, 32'h100,3);
    tbl[29] = v(0,0,0,1, 32'h200, 32'h0,        0,1,32'h200, 0,32'hdeadbeef, 32'h100,3);

    // Reset held for 3 cycles
    rst_n = 1'b0; redirect = 0; imem_ready = 0; imem_rvalid = 0; instr_ready = 0;
    pc = 32'h0; imem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk_all($sformatf("reset%0d", i), 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    end

    // Directed table; the first row releases reset
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      redirect = tbl[i].rd; imem_ready = tbl[i].rdy; imem_rvalid = tbl[i].rv;
      instr_ready = tbl[i].ir; pc = tbl[i].pc; imem_rdata = tbl[i].rdata;
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].e_pe, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_val,
              tbl[i].e_instr, tbl[i].e_ipc, tbl[i].e_cnt);
    end

    // Reset asserted mid-WAIT: outputs return to reset values at once
    @(negedge clk);
    imem_ready = 1; pc = 32'h200; #1;
    chk("midwait accept pc_en", {31'd0, pc_en}, 32'd1);
    @(negedge clk);
    imem_ready = 0; pc = 32'h204; #1;
    chk("midwait in WAIT req", {31'd0, imem_req}, 32'd0);
    #1 rst_n = 1'b0; redirect = 1; #1;
    chk_all("midwait reset", 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; redirect = 0; imem_rvalid = 1; imem_rdata = 32'h12345678; #1;
    chk_all("post-reset idle", 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk_all($sformatf("stray rvalid%0d", i), 0, 1, 32'h204, 0, 32'h0, 32'h0, 32'h0);
    end

    // Randomized traffic against the behavioural model
    @(negedge clk);
    rst_n = 1'b0; imem_rvalid = 0;
    m_started = 0; m_busy = 0; m_hold = 0; m_drop = 0; mem_pend = 0; mem_lat = 0;
    m_instr = 0; m_ipc = 0; m_pend = 0; m_cnt = 0; tpc = 32'h1000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst_n = 1'b1;
      redirect    = ($urandom % 8) == 0;
      imem_ready  = ($urandom % 3) != 0;
      instr_ready = ($urandom % 2) != 0;
      imem_rdata  = $urandom;
      pc          = tpc;
      tgt         = $urandom & 32'hffff_fffc;
      imem_rvalid = mem_pend ? (mem_lat == 0) : (($urandom % 6) == 0);
      e_fetch = m_started && !m_busy && !m_hold;
      e_req   = e_fetch && !redirect;
      e_pe    = (e_req && imem_ready) || redirect;
      #1;
      chk_all($sformatf("rand%0d", cyc), e_pe, e_req, e_fetch ? pc : 32'h0, m_hold,
              m_instr, m_ipc, m_cnt);
      @(posedge clk);
      if (mem_pend) begin
        if (mem_lat == 0) mem_pend = 0;
        else mem_lat--;
      end
      if (!m_started) begin
        m_started = 1;
      end else if (m_hold) begin
        if (redirect) m_hold = 0;
        else if (instr_ready) begin m_cnt = m_cnt + 1; m_hold = 0; end
      end else if (m_busy) begin
        if (imem_rvalid) begin
          m_busy = 0;
          if (m_drop || redirect) m_drop = 0;
          else begin m_instr = imem_rdata; m_ipc = m_pend; m_hold = 1; end
        end else if (redirect) begin
          m_drop = 1;
        end
      end else if (e_req && imem_ready) begin
        m_busy = 1; m_pend = pc; mem_pend = 1; mem_lat = $urandom_range(0, 3);
      end
      if (e_pe) tpc = redirect ? tgt : tpc + 32'd4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
